mips_cpu_bus_stall_mem: RTL

Bus-side slave memory for the Avalon-style MIPS CPU bus: the block directly downstream of `mips_cpu_bus`, answering its `read`/`write` requests from a word array. It holds the bus with `waitrequest` for a fixed or pseudo-random number of cycles per transaction, so CPU stall handling is exercised deterministically. It also monitors the master for protocol violations and counts completed transactions, so benches can check bus behaviour without extra glue.

---
 rtl/mips_cpu_bus_stall_mem.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_bus_stall_mem.sv
// Avalon-style slave memory for the MIPS CPU bus with programmable wait states,
// protocol-violation monitoring and completed-transaction counters.
module mips_cpu_bus_stall_mem #(
    parameter string RAM_INIT_FILE = "",
    parameter int    ADDR_W        = 12,
    parameter int    WAIT_CYCLES   = 0,
    parameter int    RANDOM_WAIT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_error,
    output logic [15:0] read_count,
    output logic [15:0] write_count
);

    typedef enum logic {
        IDLE,
        STALL
    } state_e;

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [0:DEPTH-1];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        err_q, err_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;

    logic              req;
    logic [3:0]        n_wait;
    logic [7:0]        lfsr_step;
    logic              viol;
    logic              do_rd;
    logic              do_wr;
    logic [ADDR_W-1:0] do_idx;
    logic [31:0]       do_wdata;
    logic [3:0]        do_be;
    logic              unused_addr;

    assign req       = read | write;
    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign n_wait    = (RANDOM_WAIT != 0) ? {2'b00, lfsr_q[1:0]} : 4'(WAIT_CYCLES);

    assign unused_addr = ^address[31:ADDR_W+2];

    assign protocol_error = err_q;
    assign read_count     = rd_cnt_q;
    assign write_count    = wr_cnt_q;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'h0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        viol        = 1'b0;
        waitrequest = 1'b0;
        do_rd       = 1'b0;
        do_wr       = 1'b0;
        do_idx      = address[ADDR_W+1:2];
        do_wdata    = writedata;
        do_be       = byteenable;

        if (reset) begin
            if (read && write) begin
                viol = 1'b1;
            end
            if (req && (address[1:0] != 2'b00)) begin
                viol = 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        lfsr_d = lfsr_step;
                        if (n_wait == 4'd0) begin
                            do_rd = read;
                            do_wr = write & ~read;
                        end else begin
                            waitrequest = 1'b1;
                            addr_d      = address;
                            wdata_d     = writedata;
                            be_d        = byteenable;
                            rd_d        = read;
                            wr_d        = write;
                            cnt_d       = n_wait - 4'd1;
                            state_d     = STALL;
                        end
                    end
                end
                STALL: begin
                    if (!req) begin
                        viol    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if ((address != addr_q) || (writedata != wdata_q) ||
                            (byteenable != be_q) || (read != rd_q) ||
                            (write != wr_q)) begin
                            viol = 1'b1;
                        end
                        if (cnt_q != 4'd0) begin
                            waitrequest = 1'b1;
                            cnt_d       = cnt_q - 4'd1;
                        end else begin
                            do_rd    = rd_q;
                            do_wr    = wr_q & ~rd_q;
                            do_idx   = addr_q[ADDR_W+1:2];
                            do_wdata = wdata_q;
                            do_be    = be_q;
                            state_d  = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        readdata = 32'h0;
        if (do_rd) begin
            readdata = mem[do_idx];
        end
    end

    always_comb begin
        err_d    = err_q | viol;
        rd_cnt_d = rd_cnt_q + {15'd0, do_rd};
        wr_cnt_d = wr_cnt_q + {15'd0, do_wr};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            lfsr_q   <= 8'hA5;
            err_q    <= 1'b0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (do_be[i]) begin
                    mem[do_idx][8*i +: 8] <= do_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
